// File: rtl/delay_line_pkg.sv
// rtl/delay_line_pkg.sv - shared state encodings and default timing for the delay-line PLL supervisor
package delay_line_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILISE = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  // 12 MHz reference, 135 MHz delay-line domain
  localparam int DEF_RESET_CYCLES        = 12;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 1200;
  localparam int DEF_LOCK_STABLE_CYCLES  = 240;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_CNT_W               = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/delay_line_sync.sv
// rtl/delay_line_sync.sv - parameterised 2-flop synchroniser for asynchronous status bits
module delay_line_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/delay_line_pll_ctrl.sv
// rtl/delay_line_pll_ctrl.sv - PLL reset sequencing, lock qualification and core reset release
module delay_line_pll_ctrl
  import delay_line_pkg::*;
#(
  parameter int RESET_CYCLES        = DEF_RESET_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  input  logic             restart_req,
  output logic             pll_resetb,
  output logic             core_rst,
  output logic             ready,
  output logic             fault,
  output logic [CNT_W-1:0] lock_loss_count,
  output logic [2:0]       state
);

  localparam int TMAX = max3(RESET_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int RW   = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] RST_LAST  = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] STB_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  state_t          st;
  logic [TW-1:0]   timer;
  logic [RW-1:0]   retry_cnt;
  logic [RW-1:0]   retry_next;
  logic            lock_s;

  delay_line_sync #(.WIDTH(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  assign retry_next = retry_cnt + 1'b1;
  assign state      = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st              <= ST_RESET_PLL;
      timer           <= '0;
      retry_cnt       <= '0;
      pll_resetb      <= 1'b0;
      core_rst        <= 1'b1;
      ready           <= 1'b0;
      fault           <= 1'b0;
      lock_loss_count <= '0;
    end else if (restart_req) begin
      // restart beats every other transition, including a coincident lock loss
      st         <= ST_RESET_PLL;
      timer      <= '0;
      retry_cnt  <= '0;
      pll_resetb <= 1'b0;
      core_rst   <= 1'b1;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      case (st)
        ST_RESET_PLL: begin
          if (timer == RST_LAST) begin
            st         <= ST_WAIT_LOCK;
            timer      <= '0;
            pll_resetb <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            st    <= ST_STABILISE;
            timer <= '0;
          end else if (timer == TO_LAST) begin
            retry_cnt  <= retry_next;
            timer      <= '0;
            pll_resetb <= 1'b0;
            if (retry_next == RETRY_MAX) begin
              st    <= ST_FAULT;
              fault <= 1'b1;
            end else begin
              st <= ST_RESET_PLL;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_STABILISE: begin
          if (!lock_s) begin
            st    <= ST_WAIT_LOCK;
            timer <= '0;
          end else if (timer == STB_LAST) begin
            st        <= ST_RUN;
            timer     <= '0;
            retry_cnt <= '0;
            core_rst  <= 1'b0;
            ready     <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            st       <= ST_LOST;
            core_rst <= 1'b1;
            ready    <= 1'b0;
            if (lock_loss_count != {CNT_W{1'b1}})
              lock_loss_count <= lock_loss_count + 1'b1;
          end
        end
        ST_LOST: begin
          st         <= ST_RESET_PLL;
          timer      <= '0;
          pll_resetb <= 1'b0;
        end
        ST_FAULT: begin
          pll_resetb <= 1'b0;
          core_rst   <= 1'b1;
          ready      <= 1'b0;
          fault      <= 1'b1;
        end
        default: begin
          st         <= ST_RESET_PLL;
          timer      <= '0;
          pll_resetb <= 1'b0;
          core_rst   <= 1'b1;
          ready      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_line_pll_ctrl.sv
// tb/tb_delay_line_pll_ctrl.sv - directed self-checking bench for delay_line_pll_ctrl
module tb_delay_line_pll_ctrl;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       restart_req;
  logic       pll_resetb;
  logic       core_rst;
  logic       ready;
  logic       fault;
  logic [1:0] lock_loss_count;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  delay_line_pll_ctrl #(
    .RESET_CYCLES        (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2),
    .CNT_W               (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pll_lock        (pll_lock),
    .restart_req     (restart_req),
    .pll_resetb      (pll_resetb),
    .core_rst        (core_rst),
    .ready           (ready),
    .fault           (fault),
    .lock_loss_count (lock_loss_count),
    .state           (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; pll_lock = 1'b0; restart_req = 1'b0;
    repeat (3) tick();
    checks++;
    if ({state, pll_resetb, core_rst, ready, fault, lock_loss_count} !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_values got st=%0d rb=%b cr=%b rdy=%b flt=%b cnt=%0d exp st=0 rb=0 cr=1 rdy=0 flt=0 cnt=0",
               state, pll_resetb, core_rst, ready, fault, lock_loss_count);
    end
  endtask

  task automatic test_bringup;
    rst = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      checks++;
      if (n < 4 && {state, pll_resetb} !== {3'd0, 1'b0}) begin
        errors++;
        $display("FAIL bringup_resetb_low n=%0d got st=%0d rb=%b exp st=0 rb=0", n, state, pll_resetb);
      end else if (n == 4 && {state, pll_resetb} !== {3'd1, 1'b1}) begin
        errors++;
        $display("FAIL bringup_resetb_rise got st=%0d rb=%b exp st=1 rb=1", state, pll_resetb);
      end
    end
    repeat (5) tick();
    pll_lock = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      tick();
      if (n == 3) begin
        checks++;
        if (state !== 3'd2) begin
          errors++;
          $display("FAIL bringup_stabilise got st=%0d exp 2", state);
        end
      end
      if (n == 10) begin
        checks++;
        if ({core_rst, ready} !== 2'b10) begin
          errors++;
          $display("FAIL bringup_early_release got cr=%b rdy=%b exp cr=1 rdy=0", core_rst, ready);
        end
      end
      if (n == 11) begin
        checks++;
        if ({state, core_rst, ready, fault} !== {3'd3, 1'b0, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL bringup_release got st=%0d cr=%b rdy=%b flt=%b exp st=3 cr=0 rdy=1 flt=0",
                   state, core_rst, ready, fault);
        end
      end
    end
  endtask

  task automatic test_glitch;
    pll_lock = 1'b0; restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    checks++;
    if ({state, core_rst, ready, fault} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL glitch_restart got st=%0d cr=%b rdy=%b flt=%b exp st=0 cr=1 rdy=0 flt=0",
               state, core_rst, ready, fault);
    end
    repeat (4) tick();
    pll_lock = 1'b1;
    repeat (5) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      tick();
      if (n == 1 || n == 2 || n == 10) begin
        checks++;
        if (state !== ((n == 2) ? 3'd1 : 3'd2)) begin
          errors++;
          $display("FAIL glitch_state n=%0d got st=%0d exp %0d", n, state, (n == 2) ? 1 : 2);
        end
      end
      if (n == 11) begin
        checks++;
        if ({state, ready, fault} !== {3'd3, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL glitch_release got st=%0d rdy=%b flt=%b exp st=3 rdy=1 flt=0", state, ready, fault);
        end
      end
    end
  endtask

  task automatic test_lock_loss;
    int n;
    pll_lock = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 2) begin
        checks++;
        if ({state, core_rst} !== {3'd3, 1'b0}) begin
          errors++;
          $display("FAIL loss_sync_delay got st=%0d cr=%b exp st=3 cr=0", state, core_rst);
        end
      end
      if (k == 3) begin
        checks++;
        if ({state, core_rst, ready, lock_loss_count} !== {3'd4, 1'b1, 1'b0, 2'd1}) begin
          errors++;
          $display("FAIL loss_lost got st=%0d cr=%b rdy=%b cnt=%0d exp st=4 cr=1 rdy=0 cnt=1",
                   state, core_rst, ready, lock_loss_count);
        end
      end
      if (k == 4) begin
        checks++;
        if ({state, pll_resetb} !== {3'd0, 1'b0}) begin
          errors++;
          $display("FAIL loss_reset_pll got st=%0d rb=%b exp st=0 rb=0", state, pll_resetb);
        end
      end
    end
    pll_lock = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (ready !== 1'b1 || n != 13 || lock_loss_count !== 2'd1) begin
      errors++;
      $display("FAIL loss_relock got rdy=%b cycles=%0d cnt=%0d exp rdy=1 cycles=13 cnt=1", ready, n, lock_loss_count);
    end
  endtask

  task automatic test_timeout_fault;
    pll_lock = 1'b0; restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    for (int n = 1; n <= 48; n++) begin
      tick();
      if (n == 4 || n == 28) begin
        checks++;
        if ({state, pll_resetb} !== {3'd1, 1'b1}) begin
          errors++;
          $display("FAIL timeout_wait n=%0d got st=%0d rb=%b exp st=1 rb=1", n, state, pll_resetb);
        end
      end
      if (n == 24) begin
        checks++;
        if ({state, pll_resetb, fault} !== {3'd0, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL timeout_retry got st=%0d rb=%b flt=%b exp st=0 rb=0 flt=0", state, pll_resetb, fault);
        end
      end
      if (n == 47) begin
        checks++;
        if ({state, fault} !== {3'd1, 1'b0}) begin
          errors++;
          $display("FAIL timeout_early_fault got st=%0d flt=%b exp st=1 flt=0", state, fault);
        end
      end
      if (n == 48) begin
        checks++;
        if ({state, fault, pll_resetb, core_rst, ready} !== {3'd5, 1'b1, 1'b0, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL timeout_fault got st=%0d flt=%b rb=%b cr=%b rdy=%b exp st=5 flt=1 rb=0 cr=1 rdy=0",
                   state, fault, pll_resetb, core_rst, ready);
        end
      end
    end
    repeat (3) tick();
    checks++;
    if ({state, fault} !== {3'd5, 1'b1}) begin
      errors++;
      $display("FAIL fault_hold got st=%0d flt=%b exp st=5 flt=1", state, fault);
    end
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    checks++;
    if ({state, fault, lock_loss_count} !== {3'd0, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL fault_restart got st=%0d flt=%b cnt=%0d exp st=0 flt=0 cnt=1", state, fault, lock_loss_count);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    pll_lock = 1'b1;
    n = 0;
    while (state !== 3'd2 && n < 20) begin
      tick();
      n++;
    end
    repeat (2) tick();
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL mid_reach_stabilise got st=%0d exp 2", state);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({state, pll_resetb, core_rst, ready, fault, lock_loss_count} !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL mid_reset got st=%0d rb=%b cr=%b rdy=%b flt=%b cnt=%0d exp st=0 rb=0 cr=1 rdy=0 flt=0 cnt=0",
               state, pll_resetb, core_rst, ready, fault, lock_loss_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_priority;
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    pll_lock = 1'b0;
    repeat (2) tick();
    checks++;
    if ({state, ready} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL prio_run got st=%0d rdy=%b exp st=3 rdy=1", state, ready);
    end
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    checks++;
    if ({state, core_rst, ready, lock_loss_count} !== {3'd0, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL prio_restart got st=%0d cr=%b rdy=%b cnt=%0d exp st=0 cr=1 rdy=0 cnt=0",
               state, core_rst, ready, lock_loss_count);
    end
    tick();
    checks++;
    if ({state, lock_loss_count} !== {3'd0, 2'd0}) begin
      errors++;
      $display("FAIL prio_after got st=%0d cnt=%0d exp st=0 cnt=0", state, lock_loss_count);
    end
  endtask

  task automatic test_saturation;
    int n;
    logic [1:0] exp_cnt;
    for (int k = 1; k <= 5; k++) begin
      exp_cnt = (k > 3) ? 2'd3 : 2'(k);
      pll_lock = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 30) begin
        tick();
        n++;
      end
      pll_lock = 1'b0;
      n = 0;
      while (state !== 3'd4 && n < 6) begin
        tick();
        n++;
      end
      checks++;
      if ({state, core_rst, lock_loss_count} !== {3'd4, 1'b1, exp_cnt}) begin
        errors++;
        $display("FAIL sat_loss k=%0d got st=%0d cr=%b cnt=%0d exp st=4 cr=1 cnt=%0d",
                 k, state, core_rst, lock_loss_count, exp_cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1; pll_lock = 1'b0; restart_req = 1'b0;
    test_reset();
    test_bringup();
    test_glitch();
    test_lock_loss();
    test_timeout_fault();
    test_reset_mid();
    test_priority();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
